// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   bcd_digit_t      : one packed BCD digit
//   state_t          : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_ADD3_THRESH  : digit value at or above which the add-3 correction applies
//   BCD_ADD3_VAL     : correction added to a digit before each shift
//   BCD_NINE         : digit value used when saturating an overflowed result
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Explicit encodings keep the state register layout stable for older consumers.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADD3_VAL    = 4'd3;
  localparam bcd_digit_t BCD_NINE        = 4'h9;

endpackage

// File: rtl/bcd_dabble_digit.sv
// Add-3 correction for a single BCD digit (combinational).
//   digit : scratch digit before the shift
//   adj   : digit + 3 when digit >= 5, otherwise digit unchanged
// The sum stays 4 bits wide; no carry leaves a digit.
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adj
);

  assign adj = (digit >= BCD_ADD3_THRESH) ? bcd_digit_t'(digit + BCD_ADD3_VAL) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Converts one operand at a time with valid/ready handshakes on both sides.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, wins in every state
//   in_valid   : bin_in is valid
//   in_ready   : converter idle and able to accept
//   bin_in     : unsigned binary operand, BIN_W bits
//   out_valid  : bcd_out/ovf hold a finished result
//   out_ready  : consumer takes the result
//   bcd_out    : packed BCD, digit k at [4k+3:4k], digit 0 least significant
//   ovf        : value >= 10^M
// Optional build macro BIN2BCD_SAT_EN: overflowed results read as all nines
// instead of value mod 10^M. Non-overflow results are the same in both builds.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 10,
  parameter int M     = 3,
  parameter int N     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     bcd_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [N-1:0]       scratch;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_acc;

  logic [N-1:0]       adj;
  logic [N-1:0]       scratch_nx;
  logic [BIN_W-1:0]   shreg_nx;
  logic               ovf_nx;
  logic [N-1:0]       bcd_fin;

  // Per-digit add-3 correction ahead of the shift.
  for (genvar k = 0; k < M; k++) begin : g_dig
    bcd_dabble_digit u_dig (
      .digit (scratch[4*k +: 4]),
      .adj   (adj[4*k +: 4])
    );
  end

  // {scratch, shreg} << 1. The bit leaving the top digit is the 10^M carry:
  // dropping it keeps the residue mod 10^M and it feeds the sticky overflow.
  assign scratch_nx = {adj[N-2:0], shreg[BIN_W-1]};
  assign shreg_nx   = shreg << 1;
  assign ovf_nx     = ovf_acc | adj[N-1];

`ifdef BIN2BCD_SAT_EN
  assign bcd_fin = ovf_nx ? {M{BCD_NINE}} : scratch_nx;
`else
  assign bcd_fin = scratch_nx;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg   <= bin_in;
          scratch <= '0;
          ovf_acc <= 1'b0;
          cnt     <= CNT_W'(BIN_W);
          state   <= SHIFT;
        end
        SHIFT: begin
          scratch <= scratch_nx;
          shreg   <= shreg_nx;
          ovf_acc <= ovf_nx;
          cnt     <= cnt - 1'b1;
          // Last bit: publish the post-shift value directly so the outputs
          // never expose partial scratch contents.
          if (cnt == CNT_W'(1)) begin
            bcd_out <= bcd_fin;
            ovf     <= ovf_nx;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=10, M=3, N=12).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  bin_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd_out;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(10), .M(3), .N(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .ovf       (ovf)
  );

  // Presents v, counts rising edges (including the accepting one) until
  // out_valid is seen, captures the result and leaves it in DONE.
  task automatic start_and_wait(input logic [9:0] v, output int lat, output bit timeout);
    @(negedge clk);
    bin_in   = v;
    in_valid = 1'b1;
    lat      = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 40);
    timeout = !out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bin_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== 12'h000 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b bcd=%h ovf=%b want 1 0 000 0",
               in_ready, out_valid, bcd_out, ovf);
    end
  endtask

  task automatic test_convert();
    logic [9:0]  vin [3] = '{10'd999, 10'd0, 10'd1};
    logic [11:0] vexp[3] = '{12'h999, 12'h000, 12'h001};
    int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      start_and_wait(vin[i], lat, to);
      tests++;
      if (to || bcd_out !== vexp[i] || ovf !== 1'b0) begin
        fails++;
        $display("FAIL convert %0d: bcd=%h ovf=%b timeout=%0d want %h 0", vin[i], bcd_out, ovf, to, vexp[i]);
      end
      tests++;
      if (lat != 11) begin
        fails++;
        $display("FAIL latency %0d: got %0d edges want 11", vin[i], lat);
      end
      consume();
    end
  endtask

  task automatic test_overflow();
    int lat; bit to;
    logic [11:0] exp_b;
`ifdef BIN2BCD_SAT_EN
    exp_b = 12'h999;
`else
    exp_b = 12'h023;
`endif
    start_and_wait(10'd1023, lat, to);
    tests++;
    if (to || bcd_out !== exp_b || ovf !== 1'b1) begin
      fails++;
      $display("FAIL overflow 1023: bcd=%h ovf=%b want %h 1", bcd_out, ovf, exp_b);
    end
    consume();
  endtask

  task automatic test_hold();
    int lat; bit to;
    start_and_wait(10'd999, lat, to);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      bin_in   = 10'(100 + i);
      @(posedge clk); #1;
      tests++;
      if (to || out_valid !== 1'b1 || in_ready !== 1'b0 || bcd_out !== 12'h999 || ovf !== 1'b0) begin
        fails++;
        $display("FAIL hold cyc%0d: ov=%b ir=%b bcd=%h ovf=%b want 1 0 999 0",
                 i, out_valid, in_ready, bcd_out, ovf);
      end
    end
    in_valid = 1'b0;
    consume();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd_out !== 12'h999) begin
      fails++;
      $display("FAIL hold release: ov=%b ir=%b bcd=%h want 0 1 999", out_valid, in_ready, bcd_out);
    end
  endtask

  task automatic test_reset_midway();
    int lat; bit to; bit seen;
    @(negedge clk);
    bin_in = 10'd300; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;      // accepted, SHIFT cycle 1
    repeat (3) @(posedge clk);               // now in SHIFT cycle 4
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== 12'h000) begin
      fails++;
      $display("FAIL rst_shift: ir=%b ov=%b bcd=%h want 1 0 000", in_ready, out_valid, bcd_out);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rst_shift_pulse: out_valid=1 want 0");
    end
    start_and_wait(10'd512, lat, to);
    tests++;
    if (to || bcd_out !== 12'h512 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL after_rst 512: bcd=%h ovf=%b want 512 0", bcd_out, ovf);
    end
    // Reset while holding a result in DONE.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd_out !== 12'h000 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL rst_done: ov=%b ir=%b bcd=%h ovf=%b want 0 1 000 0",
               out_valid, in_ready, bcd_out, ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] res[2];
    int          cyc[2];
    int          n = 0;
    @(negedge clk);
    bin_in = 10'd37; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 60 && n < 2; c++) begin
      @(posedge clk); #1;
      if (c == 1) bin_in = 10'd600;          // change during the first conversion
      if (out_valid) begin
        res[n] = bcd_out;
        cyc[n] = c;
        n++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d results want 2", n);
    end else begin
      tests++;
      if (res[0] !== 12'h037 || res[1] !== 12'h600) begin
        fails++;
        $display("FAIL b2b_data: got %h %h want 037 600", res[0], res[1]);
      end
      tests++;
      if (cyc[1] - cyc[0] != 12) begin
        fails++;
        $display("FAIL b2b_spacing: got %0d want 12", cyc[1] - cyc[0]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_hold();
    test_reset_midway();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
